// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan
// Description : Multiplexed seven-segment display scanner. Cycles a one-hot
//               digit select through NDIG digits, each held for PRESC clocks,
//               and drives the glyph, decimal point and frame marker for the
//               digit currently selected. Display contents are taken from
//               shadow registers that are written on a LOAD strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
  parameter int NDIG       = 4,
  parameter int PRESC      = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [4*NDIG-1:0] data_i,
  input  logic [NDIG-1:0]   dp_i,
  input  logic [NDIG-1:0]   blank_i,
  input  logic              hex_i,
  input  logic              lzs_i,
  output logic [6:0]        segs_o,
  output logic              dpo_o,
  output logic [NDIG-1:0]   digs_o,
  output logic              frame_o
);

  localparam int              PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int              IW         = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC - 1);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
  // Idle level of the display pins; high when the board drives them inverted.
  localparam logic [6:0]      SEGS_OFF   = {7{ACTIVE_LOW}};
  localparam logic [NDIG-1:0] DIGS_OFF   = {NDIG{ACTIVE_LOW}};

  // Scan state
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              wrap_q, wrap_d;
  logic              tick;

  // Shadow copies of the display contents
  logic [4*NDIG-1:0] data_q;
  logic [NDIG-1:0]   dp_q;
  logic [NDIG-1:0]   blank_q;

  // Output registers (already at pin polarity)
  logic [6:0]        segs_q, segs_d;
  logic              dpo_q, dpo_d;
  logic [NDIG-1:0]   digs_q, digs_d;
  logic              frame_q;

  // Selected-digit view of the shadow state
  logic [3:0]        sel_nib;
  logic              sel_dp;
  logic              sel_blank;
  logic              sel_zero_above;
  logic              zero_acc;
  logic              suppress;
  logic [NDIG-1:0]   onehot;

  // Active-high glyph for one nibble; decimal mode turns A-F into a dash.
  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    if (!hex && (nib > 4'd9)) begin
      g = 7'h01;
    end
    return g;
  endfunction

  // Prescaler and digit index advance; wrap_d marks the index returning to 0.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    wrap_d  = tick && (idx_q == IDX_LAST);
  end

  // Pick out the current digit's nibble, flags, and whether it and every
  // more-significant nibble are zero (used for leading-zero suppression).
  always_comb begin
    sel_nib        = '0;
    sel_dp         = 1'b0;
    sel_blank      = 1'b0;
    sel_zero_above = 1'b0;
    zero_acc       = 1'b1;
    onehot         = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_acc = zero_acc && (data_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        sel_nib        = data_q[4*i +: 4];
        sel_dp         = dp_q[i];
        sel_blank      = blank_q[i];
        sel_zero_above = zero_acc;
        onehot[i]      = 1'b1;
      end
    end
  end

  // Compose the next pin values: blank beats suppression beats the glyph,
  // and a disabled display idles every pin while the scan carries on.
  always_comb begin
    suppress = lzs_i && (idx_q != '0) && sel_zero_above;
    segs_d   = '0;
    dpo_d    = 1'b0;
    digs_d   = '0;
    if (en_i) begin
      digs_d = onehot;
      if (!sel_blank) begin
        dpo_d  = sel_dp;
        segs_d = suppress ? 7'h00 : glyph(sel_nib, hex_i);
      end
    end
  end

  // Scan counters and shadow register capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      if (load_i) begin
        data_q  <= data_i;
        dp_q    <= dp_i;
        blank_q <= blank_i;
      end
    end
  end

  // Output registers; polarity applied here so the pins come straight off flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      segs_q  <= SEGS_OFF;
      dpo_q   <= ACTIVE_LOW;
      digs_q  <= DIGS_OFF;
      frame_q <= 1'b0;
    end else begin
      segs_q  <= segs_d ^ SEGS_OFF;
      dpo_q   <= dpo_d ^ ACTIVE_LOW;
      digs_q  <= digs_d ^ DIGS_OFF;
      frame_q <= wrap_q;
    end
  end

  assign segs_o  = segs_q;
  assign dpo_o   = dpo_q;
  assign digs_o  = digs_q;
  assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan
// Description : Directed bench for seven_seg_scan (NDIG=4, PRESC=4), with an
//               active-high and an active-low instance sharing all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst, en, load, hex, lzs;
  logic [15:0] data;
  logic [3:0]  dp, blank;

  logic [6:0]  segs_h, segs_l;
  logic        dpo_h, dpo_l, frame_h, frame_l;
  logic [3:0]  digs_h, digs_l;

  int checks = 0;
  int errors = 0;
  int k      = 0;   // edges since reset release; 0 = first edge with rst low

  always #5 clk = ~clk;

  seven_seg_scan #(.NDIG(4), .PRESC(4), .ACTIVE_LOW(1'b0)) u_hi (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .data_i(data),
    .dp_i(dp), .blank_i(blank), .hex_i(hex), .lzs_i(lzs),
    .segs_o(segs_h), .dpo_o(dpo_h), .digs_o(digs_h), .frame_o(frame_h));

  seven_seg_scan #(.NDIG(4), .PRESC(4), .ACTIVE_LOW(1'b1)) u_lo (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .data_i(data),
    .dp_i(dp), .blank_i(blank), .hex_i(hex), .lzs_i(lzs),
    .segs_o(segs_l), .dpo_o(dpo_l), .digs_o(digs_l), .frame_o(frame_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Both instances show their idle levels and no frame pulse.
  task automatic chk_idle(input string tag);
    chk({tag, " segs"},     {25'd0, segs_h},  32'h00);
    chk({tag, " dpo"},      {31'd0, dpo_h},   32'h0);
    chk({tag, " digs"},     {28'd0, digs_h},  32'h0);
    chk({tag, " frame"},    {31'd0, frame_h}, 32'h0);
    chk({tag, " al segs"},  {25'd0, segs_l},  32'h7F);
    chk({tag, " al dpo"},   {31'd0, dpo_l},   32'h1);
    chk({tag, " al digs"},  {28'd0, digs_l},  32'hF);
    chk({tag, " al frame"}, {31'd0, frame_l}, 32'h0);
  endtask

  // Advance until the next edge will begin a new frame (digit 0 shown).
  task automatic to_frame();
    while ((k % 16) != 15) tick();
  endtask

  // Run n edges checking both instances against per-digit expected segments
  // (segtab packs digit d at [7d+6:7d]) and decimal points.
  task automatic run(input int n, input logic [27:0] segtab, input logic [3:0] dptab);
    int         d;
    logic [6:0] es;
    logic       ed, ef;
    logic [3:0] eg;
    for (int i = 0; i < n; i++) begin
      tick();
      d  = (k / 4) % 4;
      es = en ? segtab[7*d +: 7] : 7'h00;
      ed = en ? dptab[d] : 1'b0;
      eg = en ? (4'b0001 << d) : 4'b0000;
      ef = (k > 0) && ((k % 16) == 0);
      chk($sformatf("segs k=%0d", k),     {25'd0, segs_h},  {25'd0, es});
      chk($sformatf("dpo k=%0d", k),      {31'd0, dpo_h},   {31'd0, ed});
      chk($sformatf("digs k=%0d", k),     {28'd0, digs_h},  {28'd0, eg});
      chk($sformatf("frame k=%0d", k),    {31'd0, frame_h}, {31'd0, ef});
      chk($sformatf("al segs k=%0d", k),  {25'd0, segs_l},  {25'd0, ~es});
      chk($sformatf("al dpo k=%0d", k),   {31'd0, dpo_l},   {31'd0, ~ed});
      chk($sformatf("al digs k=%0d", k),  {28'd0, digs_l},  {28'd0, ~eg});
      chk($sformatf("al frame k=%0d", k), {31'd0, frame_l}, {31'd0, ef});
    end
  endtask

  task automatic load_regs(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data = d; dp = p; blank = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; hex = 1'b1; lzs = 1'b0;
    data = '0; dp = '0; blank = '0;

    // Reset held for two edges: idle outputs.
    tick(); chk_idle("reset1");
    tick(); chk_idle("reset2");

    // Release: digit 0..3 for 4 cycles each, all 7E, first frame at k=16.
    rst = 1'b0; en = 1'b1; hex = 1'b1; k = -1;
    run(17, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000);

    // Load lands one cycle after the strobe edge (k=16 shows digit 0).
    load_regs(16'h1234, 4'b0000, 4'b0000);
    chk("load lag old", {25'd0, segs_h}, 32'h7E);
    tick();
    chk("load lag new", {25'd0, segs_h}, 32'h33);

    // Hex display across two full frames.
    to_frame();
    run(32, {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0000);

    // Leading-zero suppression.
    lzs = 1'b1;
    load_regs(16'h0005, 4'b0000, 4'b0000);
    to_frame();
    run(16, {7'h00, 7'h00, 7'h00, 7'h5B}, 4'b0000);
    load_regs(16'h0000, 4'b0000, 4'b0000);
    to_frame();
    run(16, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000);

    // Decimal mode: A-F become a dash.
    lzs = 1'b0; hex = 1'b0;
    load_regs(16'hA9F0, 4'b0000, 4'b0000);
    to_frame();
    run(16, {7'h01, 7'h7B, 7'h01, 7'h7E}, 4'b0000);

    // Decimal points and blanking; blank on digit 2 overrides its DP.
    hex = 1'b1;
    load_regs(16'h1234, 4'b0110, 4'b0100);
    to_frame();
    run(16, {7'h30, 7'h00, 7'h79, 7'h33}, 4'b0010);

    // Display disabled: pins idle, scan and frame keep running.
    en = 1'b0;
    to_frame();
    run(16, {7'h30, 7'h00, 7'h79, 7'h33}, 4'b0010);
    en = 1'b1;
    to_frame();
    run(4, {7'h30, 7'h00, 7'h79, 7'h33}, 4'b0010);

    // Reset mid-scan with a simultaneous load: the load is discarded.
    while (((k / 4) % 4) != 2) tick();
    rst = 1'b1; load = 1'b1; data = 16'hFFFF; dp = 4'b1111; blank = 4'b0000;
    tick();
    chk_idle("midscan reset");
    rst = 1'b0; load = 1'b0; k = -1;
    run(17, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
